alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin arbiter letting two requesters share a single
//             combinational ALU. One operation is in flight at a time: the
//             granted request is latched into operand registers that drive
//             the ALU, the result is captured after EVAL_CYCLES cycles and
//             held as a response until the consumer accepts it.
//  Ports    : clk, rst                      clock, synchronous active-high reset
//             req{0,1}_valid / _ready       request handshake per requester
//             req{0,1}_opcode/rs/rt/shamt/funct/imm  operation fields
//             alu_*                         operands to the shared ALU
//             alu_result, alu_sig_branch    results from the shared ALU
//             rsp_valid/ready/id/result/branch  response channel
//             busy                          high while an operation is in flight
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int unsigned EVAL_CYCLES = 1      // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_opcode,
    input  logic [31:0] req0_rs,
    input  logic [31:0] req0_rt,
    input  logic [4:0]  req0_shamt,
    input  logic [5:0]  req0_funct,
    input  logic [15:0] req0_imm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_opcode,
    input  logic [31:0] req1_rs,
    input  logic [31:0] req1_rt,
    input  logic [4:0]  req1_shamt,
    input  logic [5:0]  req1_funct,
    input  logic [15:0] req1_imm,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_rs_content,
    output logic [31:0] alu_rt_content,
    output logic [4:0]  alu_shamt,
    output logic [5:0]  alu_ALU_control,
    output logic [15:0] alu_immediate,
    input  logic [31:0] alu_result,
    input  logic        alu_sig_branch,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_branch,
    output logic        busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EVAL = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Counter counts down to zero, so EVAL lasts exactly EVAL_CYCLES cycles.
    localparam logic [3:0] c_CNT_LOAD = 4'(EVAL_CYCLES - 1);

    logic [1:0]  r_state,      w_state_nxt;
    logic [3:0]  r_cnt,        w_cnt_nxt;
    logic        r_last_grant, w_last_grant_nxt;
    logic        r_rsp_valid,  w_rsp_valid_nxt;
    logic        r_rsp_id,     w_rsp_id_nxt;
    logic [31:0] r_rsp_result, w_rsp_result_nxt;
    logic        r_rsp_branch, w_rsp_branch_nxt;
    logic [5:0]  r_opcode,     w_opcode_nxt;
    logic [31:0] r_rs,         w_rs_nxt;
    logic [31:0] r_rt,         w_rt_nxt;
    logic [4:0]  r_shamt,      w_shamt_nxt;
    logic [5:0]  r_funct,      w_funct_nxt;
    logic [15:0] r_imm,        w_imm_nxt;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;

    // Grant only in IDLE and never while reset is asserted. On contention the
    // requester that did not own the previous response wins.
    assign w_idle   = (r_state == c_IDLE);
    assign w_grant0 = w_idle & ~rst & req0_valid & (~req1_valid |  r_last_grant);
    assign w_grant1 = w_idle & ~rst & req1_valid & (~req0_valid | ~r_last_grant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_id_nxt     = r_rsp_id;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_branch_nxt = r_rsp_branch;
        w_opcode_nxt     = r_opcode;
        w_rs_nxt         = r_rs;
        w_rt_nxt         = r_rt;
        w_shamt_nxt      = r_shamt;
        w_funct_nxt      = r_funct;
        w_imm_nxt        = r_imm;

        case (r_state)
            c_IDLE: begin
                if (w_grant0 | w_grant1) begin
                    w_opcode_nxt = w_grant1 ? req1_opcode : req0_opcode;
                    w_rs_nxt     = w_grant1 ? req1_rs     : req0_rs;
                    w_rt_nxt     = w_grant1 ? req1_rt     : req0_rt;
                    w_shamt_nxt  = w_grant1 ? req1_shamt  : req0_shamt;
                    w_funct_nxt  = w_grant1 ? req1_funct  : req0_funct;
                    w_imm_nxt    = w_grant1 ? req1_imm    : req0_imm;
                    w_rsp_id_nxt = w_grant1;
                    w_cnt_nxt    = c_CNT_LOAD;
                    w_state_nxt  = c_EVAL;
                end
            end
            c_EVAL: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_rsp_result_nxt = alu_result;
                    w_rsp_branch_nxt = alu_sig_branch;
                    w_rsp_valid_nxt  = 1'b1;
                    w_state_nxt      = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt  = 1'b0;
                    w_last_grant_nxt = r_rsp_id;
                    w_state_nxt      = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_branch <= 1'b0;
            r_opcode     <= 6'd0;
            r_rs         <= 32'd0;
            r_rt         <= 32'd0;
            r_shamt      <= 5'd0;
            r_funct      <= 6'd0;
            r_imm        <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_id     <= w_rsp_id_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_branch <= w_rsp_branch_nxt;
            r_opcode     <= w_opcode_nxt;
            r_rs         <= w_rs_nxt;
            r_rt         <= w_rt_nxt;
            r_shamt      <= w_shamt_nxt;
            r_funct      <= w_funct_nxt;
            r_imm        <= w_imm_nxt;
        end
    end

    // The ALU sees only registered operands, so its inputs stay stable for
    // the whole of EVAL and RESP regardless of what requesters do.
    assign alu_opcode      = r_opcode;
    assign alu_rs_content  = r_rs;
    assign alu_rt_content  = r_rt;
    assign alu_shamt       = r_shamt;
    assign alu_ALU_control = r_funct;
    assign alu_immediate   = r_imm;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_branch = r_rsp_branch;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter. Two instances
//             share request inputs: dut_a uses EVAL_CYCLES=1, dut_b uses
//             EVAL_CYCLES=4. Each drives a behavioural model of the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam logic [5:0] c_XOR = 6'b100110;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [5:0]  req0_opcode, req1_opcode, req0_funct, req1_funct;
    logic [31:0] req0_rs, req1_rs, req0_rt, req1_rt;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [15:0] req0_imm, req1_imm;

    logic        a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready;
    logic [5:0]  a_alu_opcode, a_alu_funct, b_alu_opcode, b_alu_funct;
    logic [31:0] a_alu_rs, a_alu_rt, b_alu_rs, b_alu_rt;
    logic [4:0]  a_alu_shamt, b_alu_shamt;
    logic [15:0] a_alu_imm, b_alu_imm;
    logic [31:0] a_alu_result, b_alu_result;
    logic        a_alu_sig_branch, b_alu_sig_branch;
    logic        a_rsp_valid, a_rsp_id, a_rsp_branch, a_busy;
    logic        b_rsp_valid, b_rsp_id, b_rsp_branch, b_busy;
    logic [31:0] a_rsp_result, b_rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU: {sig_branch, result}.
    function automatic logic [32:0] alu_f(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [4:0] sh,
                                          input logic [5:0] fn, input logic [15:0] im);
        logic [31:0] r;
        logic        b;
        r = 32'd0;
        b = 1'b0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: r = rs + rt;
                    6'b100010: r = rs - rt;
                    6'b100100: r = rs & rt;
                    6'b100101: r = rs | rt;
                    6'b100110: r = rs ^ rt;
                    6'b000000: r = rt << sh;
                    default:   r = 32'd0;
                endcase
            end
            6'b000100: begin r = rs - rt; b = (rs == rt); end
            6'b000101: begin r = rs - rt; b = (rs != rt); end
            6'b001000: r = rs + {{16{im[15]}}, im};
            default:   r = 32'd0;
        endcase
        return {b, r};
    endfunction

    assign {a_alu_sig_branch, a_alu_result} =
        alu_f(a_alu_opcode, a_alu_rs, a_alu_rt, a_alu_shamt, a_alu_funct, a_alu_imm);
    assign {b_alu_sig_branch, b_alu_result} =
        alu_f(b_alu_opcode, b_alu_rs, b_alu_rt, b_alu_shamt, b_alu_funct, b_alu_imm);

    alu_arbiter #(.EVAL_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_opcode(req0_opcode),
        .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_shamt(req0_shamt),
        .req0_funct(req0_funct), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_opcode(req1_opcode),
        .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_shamt(req1_shamt),
        .req1_funct(req1_funct), .req1_imm(req1_imm),
        .alu_opcode(a_alu_opcode), .alu_rs_content(a_alu_rs), .alu_rt_content(a_alu_rt),
        .alu_shamt(a_alu_shamt), .alu_ALU_control(a_alu_funct), .alu_immediate(a_alu_imm),
        .alu_result(a_alu_result), .alu_sig_branch(a_alu_sig_branch),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id),
        .rsp_result(a_rsp_result), .rsp_branch(a_rsp_branch), .busy(a_busy)
    );

    alu_arbiter #(.EVAL_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_opcode(req0_opcode),
        .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_shamt(req0_shamt),
        .req0_funct(req0_funct), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_opcode(req1_opcode),
        .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_shamt(req1_shamt),
        .req1_funct(req1_funct), .req1_imm(req1_imm),
        .alu_opcode(b_alu_opcode), .alu_rs_content(b_alu_rs), .alu_rt_content(b_alu_rt),
        .alu_shamt(b_alu_shamt), .alu_ALU_control(b_alu_funct), .alu_immediate(b_alu_imm),
        .alu_result(b_alu_result), .alu_sig_branch(b_alu_sig_branch),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id),
        .rsp_result(b_rsp_result), .rsp_branch(b_rsp_branch), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [5:0] fn);
        req0_opcode = op; req0_rs = rs; req0_rt = rt; req0_funct = fn;
        req0_shamt = 5'd0; req0_imm = 16'd0;
    endtask

    task automatic set_req1(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [5:0] fn, input logic [4:0] sh, input logic [15:0] im);
        req1_opcode = op; req1_rs = rs; req1_rt = rt; req1_funct = fn;
        req1_shamt = sh; req1_imm = im;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid [4];
        int gcyc[4];
        int gcnt;
        int both;
        int lat;
        logic brcap;

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        set_req0(6'd0, 32'd0, 32'd0, 6'd0);
        set_req1(6'd0, 32'd0, 32'd0, 6'd0, 5'd0, 16'd0);

        // ---- Reset state, ready suppressed while rst high
        tick(); tick();
        req0_valid = 1'b1; #1;
        chk("rst_ready0", 32'(a_req0_ready), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_alu_rs", a_alu_rs, 32'd0);
        chk("rst_rsp_result", a_rsp_result, 32'd0);
        req0_valid = 1'b0;
        tick();
        rst = 1'b0;

        // ---- Single request: 15 xor 12 = 3, two-cycle latency
        set_req0(6'd0, 32'd15, 32'd12, c_XOR);
        req0_valid = 1'b1; #1;
        chk("t1_ready0", 32'(a_req0_ready), 32'd1);
        chk("t1_ready1", 32'(a_req1_ready), 32'd0);
        tick(); req0_valid = 1'b0; #1;
        chk("t1_busy", 32'(a_busy), 32'd1);
        chk("t1_eval_valid", 32'(a_rsp_valid), 32'd0);
        chk("t1_alu_rs", a_alu_rs, 32'd15);
        chk("t1_alu_rt", a_alu_rt, 32'd12);
        chk("t1_alu_funct", 32'(a_alu_funct), 32'(c_XOR));
        chk("t1_ready_eval", 32'(a_req0_ready), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("t1_result", a_rsp_result, 32'd3);
        chk("t1_id", 32'(a_rsp_id), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("t1_done_valid", 32'(a_rsp_valid), 32'd0);
        chk("t1_done_busy", 32'(a_busy), 32'd0);
        rsp_ready = 1'b0;

        // ---- Contention after reset: req0 first (21), then req1 (34)
        rst = 1'b1; tick(); rst = 1'b0;
        set_req0(6'd0, 32'd23, 32'd2, c_XOR);
        set_req1(6'd0, 32'd1, 32'd35, c_XOR, 5'd0, 16'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("t2_ready0", 32'(a_req0_ready), 32'd1);
        chk("t2_ready1", 32'(a_req1_ready), 32'd0);
        tick(); req0_valid = 1'b0; #1;
        chk("t2_wait_eval_r1", 32'(a_req1_ready), 32'd0);
        tick();
        chk("t2_res0", a_rsp_result, 32'd21);
        chk("t2_id0", 32'(a_rsp_id), 32'd0);
        rsp_ready = 1'b1; #1;
        chk("t2_cmpl_r1", 32'(a_req1_ready), 32'd0);
        tick();
        chk("t2_grant1", 32'(a_req1_ready), 32'd1);
        tick(); req1_valid = 1'b0;
        tick();
        chk("t2_res1", a_rsp_result, 32'd34);
        chk("t2_id1", 32'(a_rsp_id), 32'd1);
        chk("t2_valid1", 32'(a_rsp_valid), 32'd1);
        tick();

        // ---- Continuous contention: grants 0,1,0,1 spaced 3 cycles
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        gcnt = 0; both = 0;
        for (int k = 0; k < 4; k++) begin gid[k] = -1; gcyc[k] = 0; end
        for (int c = 0; c < 30 && gcnt < 4; c++) begin
            #1;
            if (a_req0_ready & a_req1_ready) both++;
            if (a_req0_ready | a_req1_ready) begin
                gid[gcnt]  = a_req1_ready ? 1 : 0;
                gcyc[gcnt] = c;
                gcnt++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t3_count", 32'(gcnt), 32'd4);
        chk("t3_both", 32'(both), 32'd0);
        for (int k = 0; k < 4; k++) chk("t3_id", 32'(gid[k]), 32'(k % 2));
        for (int k = 1; k < 4; k++) chk("t3_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);

        // ---- Back-pressure: response and ALU operands held while rsp_ready low
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b0;
        set_req1(6'd0, 32'd1, 32'd35, c_XOR, 5'd7, 16'h1234);
        req1_valid = 1'b1; #1;
        chk("t4_grant1", 32'(a_req1_ready), 32'd1);
        tick(); req1_valid = 1'b0; req0_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", 32'(a_rsp_valid), 32'd1);
            chk("t4_hold_result", a_rsp_result, 32'd34);
            chk("t4_hold_id", 32'(a_rsp_id), 32'd1);
            chk("t4_hold_imm", 32'(a_alu_imm), 32'h1234);
            chk("t4_hold_shamt", 32'(a_alu_shamt), 32'd7);
            chk("t4_hold_ready0", 32'(a_req0_ready), 32'd0);
            chk("t4_hold_busy", 32'(a_busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1; #1;
        chk("t4_last_valid", 32'(a_rsp_valid), 32'd1);
        tick();
        chk("t4_done_valid", 32'(a_rsp_valid), 32'd0);
        chk("t4_done_ready0", 32'(a_req0_ready), 32'd1);
        req0_valid = 1'b0; rsp_ready = 1'b0;

        // ---- Reset during EVAL aborts the operation
        req1_valid = 1'b1; #1;
        chk("t5_grant1", 32'(a_req1_ready), 32'd1);
        tick(); req1_valid = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_valid", 32'(a_rsp_valid), 32'd0);
        chk("t5_alu_rs", a_alu_rs, 32'd0);
        chk("t5_alu_imm", 32'(a_alu_imm), 32'd0);
        chk("t5_id", 32'(a_rsp_id), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_rsp", 32'(a_rsp_valid), 32'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("t5_prio0", 32'(a_req0_ready), 32'd1);
        chk("t5_prio1", 32'(a_req1_ready), 32'd0);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("t5_res", a_rsp_result, 32'd21);

        // ---- EVAL_CYCLES=4: latency 5, result 15, branch captured
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b0;
        set_req0(6'd0, 32'd9, 32'd6, c_XOR);
        req0_valid = 1'b1; #1;
        chk("t6_ready0", 32'(b_req0_ready), 32'd1);
        tick(); req0_valid = 1'b0;
        lat = 0; brcap = 1'bx;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (b_rsp_valid) lat = c;
            else begin
                brcap = b_alu_sig_branch;
                tick();
            end
        end
        chk("t6_latency", 32'(lat), 32'd5);
        chk("t6_result", b_rsp_result, 32'd15);
        chk("t6_branch", 32'(b_rsp_branch), 32'(brcap));
        rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        set_req0(6'b000100, 32'd7, 32'd7, 6'd0);
        req0_valid = 1'b1;
        tick(); req0_valid = 1'b0;
        repeat (3) tick();
        chk("t6_beq_early", 32'(b_rsp_valid), 32'd0);
        tick();
        chk("t6_beq_valid", 32'(b_rsp_valid), 32'd1);
        chk("t6_beq_branch", 32'(b_rsp_branch), 32'd1);
        chk("t6_beq_result", b_rsp_result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
